// File: rtl/rand_arbiter_pkg.sv
// Shared definitions for the random-word round-robin arbiter.
//   arb_state_t      : controller states (IDLE, WARMUP, RUN)
//   LFSR_MASK        : Galois feedback mask for the 16-bit LFSR
//   SEED_DEFAULT_VAL : seed used at reset and in place of a zero seed
//   lfsr_next()      : one Galois right-shift step of the LFSR
package rand_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } arb_state_t;

    localparam logic [15:0] LFSR_MASK        = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT_VAL = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr_galois16.sv
// 16-bit Galois LFSR state register.
//   clk_in      : clock
//   rst_n_in    : async active-low reset, state <= RESET_VALUE
//   load        : load load_value (has priority over step)
//   step        : advance the state by one Galois step
//   load_value  : value written on load
//   state_out   : current LFSR state
module lfsr_galois16
    import rand_arbiter_pkg::*;
#(
    parameter logic [15:0] RESET_VALUE = SEED_DEFAULT_VAL
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] load_value,
    output logic [15:0] state_out
);

    logic [15:0] s_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s_q <= RESET_VALUE;
        end else if (load) begin
            s_q <= load_value;
        end else if (step) begin
            s_q <= lfsr_next(s_q);
        end
    end

    assign state_out = s_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter that hands a 16-bit LFSR word to each granted requester.
// Optional build macro: RAND_ARBITER_ZERO_GUARD_EN -- reloads SEED_DEFAULT if
// the LFSR state is ever seen at zero, suppressing the grant that cycle.
//   clk_in / rst_n_in : clock, async active-low reset
//   seed_load_in      : one-cycle pulse, loads seed_in (zero -> SEED_DEFAULT)
//   seed_in           : seed value
//   enable_in         : permits grants in RUN
//   req_in            : per-requester level requests
//   grant_out         : registered one-hot grant, one cycle
//   valid_out         : OR of grant_out, qualifies data_out
//   data_out          : LFSR word for the granted requester
//   busy_out          : high while in WARMUP
//   grant_count_out   : grants since last seed load, wraps
//
// state  | meaning
// IDLE   | after reset, waits for a seed load; no grants, LFSR held
// WARMUP | discards WARMUP_CYCLES LFSR steps; busy_out high
// RUN    | grants one requester per cycle when enabled and requested
module rand_arbiter
    import rand_arbiter_pkg::*;
#(
    parameter int          NUM_REQ       = 4,
    parameter int          WARMUP_CYCLES = 16,
    parameter logic [15:0] SEED_DEFAULT  = SEED_DEFAULT_VAL
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               seed_load_in,
    input  logic [15:0]        seed_in,
    input  logic               enable_in,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               valid_out,
    output logic [15:0]        data_out,
    output logic               busy_out,
    output logic [15:0]        grant_count_out
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [7:0]         warm_cnt_q;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [15:0]        data_q, gcount_q, s_q;
    logic               any_win, grant_en, warm_step, fire, zero_fix;
    logic               lfsr_load;
    logic [15:0]        lfsr_load_value;

`ifdef RAND_ARBITER_ZERO_GUARD_EN
    // A zero state would lock the LFSR; a seed load already overrides it.
    assign zero_fix = (s_q == 16'h0000) && !seed_load_in;
`else
    assign zero_fix = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (seed_load_in) begin
            state_d = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
        end else begin
            case (state_q)
                // The step taken at count 1 is the last discarded one.
                ST_WARMUP: if (warm_cnt_q <= 8'd1) state_d = ST_RUN;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy_out  = (state_q == ST_WARMUP);
        warm_step = (state_q == ST_WARMUP) && !seed_load_in;
        grant_en  = (state_q == ST_RUN) && enable_in && !seed_load_in && !zero_fix;
    end

    // Round-robin search starting at the pointer.
    always_comb begin
        int idx;
        grant_d = '0;
        ptr_d   = ptr_q;
        any_win = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_win && req_in[idx]) begin
                any_win      = 1'b1;
                grant_d[idx] = 1'b1;
                ptr_d        = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    assign fire = grant_en && any_win;

    // The pointer survives seed loads; only reset returns it to 0.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            grant_q    <= '0;
            data_q     <= 16'h0000;
            gcount_q   <= 16'h0000;
            ptr_q      <= '0;
            warm_cnt_q <= 8'd0;
        end else if (seed_load_in) begin
            grant_q    <= '0;
            gcount_q   <= 16'h0000;
            warm_cnt_q <= 8'(WARMUP_CYCLES);
        end else begin
            grant_q <= fire ? grant_d : '0;
            if (fire) begin
                data_q   <= s_q;
                gcount_q <= gcount_q + 16'd1;
                ptr_q    <= ptr_d;
            end
            if (warm_step) warm_cnt_q <= warm_cnt_q - 8'd1;
        end
    end

    assign lfsr_load       = seed_load_in || zero_fix;
    assign lfsr_load_value = (seed_load_in && (seed_in != 16'h0000)) ? seed_in : SEED_DEFAULT;

    lfsr_galois16 #(
        .RESET_VALUE (SEED_DEFAULT)
    ) u_lfsr (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load       (lfsr_load),
        .step       (fire || warm_step),
        .load_value (lfsr_load_value),
        .state_out  (s_q)
    );

    assign grant_out       = grant_q;
    assign valid_out       = |grant_q;
    assign data_out        = data_q;
    assign grant_count_out = gcount_q;

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WARMUP_CYCLES, default 16, LFSR steps discarded after each seed load (0..255).
REQ-003 SHALL have parameter SEED_DEFAULT, default 16'hACE1, seed used at reset and in place of a zero seed.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk_in, rst_n_in.
REQ-005 Ports:
- clk_in  input  1  clock.
- rst_n_in  input  1  async active-low reset.
- seed_load_in  input  1  one-cycle pulse to load seed_in.
- seed_in  input  16  seed value.
- enable_in  input  1  permits grants in RUN.
- req_in  input  NUM_REQ  per-requester level request.
- grant_out  output  NUM_REQ  one-hot grant, one cycle.
- valid_out  output  1  data_out valid; equals OR of grant_out.
- data_out  output  16  random word for the granted requester.
- busy_out  output  1  high in WARMUP.
- grant_count_out  output  16  grants issued since last seed load, wraps.

Function
REQ-006 SHALL hold a 16-bit state S. Step = Galois right shift: S <= (S>>1) ^ (S[0] ? 16'hB400 : 0).
REQ-007 SHALL implement FSM states IDLE, WARMUP, RUN.
REQ-008 IDLE: no grants, S held. seed_load_in -> WARMUP.
REQ-009 On seed_load_in in any state: S <= seed_in, or SEED_DEFAULT if seed_in == 0; warmup counter <= WARMUP_CYCLES; grant_count_out <= 0; outstanding grant cancelled next cycle.
REQ-010 WARMUP: one step per cycle, busy_out = 1, no grants; counter reaching 0 -> RUN. With WARMUP_CYCLES = 0, go straight to RUN the cycle after the load.
REQ-011 RUN with enable_in = 1 and any req_in bit set: grant exactly one requester, registered, one cycle after sampling; data_out = S before the step; S steps once in the same cycle.
REQ-012 No grant in a cycle -> S held; data_out holds its last value; valid_out = 0.
REQ-013 Arbitration SHALL be round-robin. The pointer starts at 0; after a grant to i it becomes (i+1) mod NUM_REQ. The search starts at the pointer.
REQ-014 A requester holding req_in is granted once per arbitration round. A requester alone is granted every cycle.
REQ-015 Deasserting req_in in the grant cycle does not revoke an already-registered grant.
REQ-016 enable_in = 0 in RUN: no grants, S held, pointer held.
REQ-017 grant_count_out SHALL increment per grant and wrap 16'hFFFF -> 0.

Reset
REQ-018 On rst_n_in low, asynchronously:
- state IDLE, S = SEED_DEFAULT, pointer 0;
- grant_out = 0, valid_out = 0, data_out = 0;
- busy_out = 0, grant_count_out = 0.
REQ-019 Reset deassertion mid-operation: resumes in IDLE and requires seed_load_in before any grant.

Configuration
REQ-020 Macro RAND_ARBITER_ZERO_GUARD_EN defined: if S == 0 is ever detected, S <= SEED_DEFAULT the next cycle and no grant is issued that cycle.
REQ-021 Macro undefined: no zero detection logic.

Structure
REQ-022 Shared package rand_arbiter_pkg SHALL hold:
- FSM state enum;
- LFSR mask 16'hB400;
- SEED_DEFAULT default;
- step function.
REQ-023 The LFSR state and step logic SHALL be one sub-module, lfsr_galois16, with ports load, step, load value and state out. Arbiter and FSM stay in rand_arbiter.

Verification
REQ-024 Reset, then seed_load_in with seed_in = 16'h0001, WARMUP_CYCLES = 0, req_in = 4'b0001, enable_in = 1 -> data_out sequence 16'h0001, 16'hB400, 16'h5A00, 16'h2D00 on consecutive grant_out = 4'b0001.
REQ-025 seed_in = 0, WARMUP_CYCLES = 0 -> first data_out = 16'hACE1; second = 16'hE270.
REQ-026 req_in = 4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001; grant_count_out = 5.
REQ-027 WARMUP_CYCLES = 16, req held -> busy_out high exactly 16 cycles; first grant after busy_out falls.
REQ-028 seed_load_in during RUN with requests -> grants stop; WARMUP restarts; grant_count_out = 0.
REQ-029 rst_n_in pulsed low mid-grant -> grant_out = 0 immediately, asynchronously; no grant until a new seed load.
